param_fifo: RTL and testbench
=============================

// Module: param_fifo
// PURPOSE
//   Parametrised synchronous FIFO; next generation of the systolic-array operand FIFO.
//   Adds arbitrary (non-power-of-2) depth, occupancy count and almost-full/almost-empty thresholds.
//   Adds sticky overflow/underflow flags and a selectable first-word-fall-through (FWFT) or registered-read mode.
//   One instance per PE-array row/column edge; buffers operands between the loader and the array.
// PARAMETERS
//   DEPTH      32          number of entries, any integer >= 2
//   BWIDTH     8           data width in bits (INT8 operands by default)
//   AFULL_TH   DEPTH-2     IS_AFULL asserted when COUNT >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH  2           IS_AEMPTY asserted when COUNT <= AEMPTY_TH (0..DEPTH-1)
//   FWFT       1           1: head visible on D_out while non-empty; 0: registered read, 1-cycle latency
//   AW         $clog2(DEPTH) localparam, pointer width; COUNT is AW+1 bits
// PORTS
//   CLK        in   1         clock, all state on rising edge
//   RST        in   1         asynchronous, active-high reset
//   PUSHE      in   1         push request
//   POPE       in   1         pop request
//   CLR_ERR    in   1         clears OVF/UDF
//   D_in       in   BWIDTH    data to push
//   D_out      out  BWIDTH    popped/head data
//   D_valid    out  1         D_out holds valid data (see BEHAVIOUR)
//   IS_EMPTY   out  1         1 when COUNT == 0
//   IS_FULL    out  1         1 when COUNT == DEPTH
//   IS_AEMPTY  out  1         1 when COUNT <= AEMPTY_TH
//   IS_AFULL   out  1         1 when COUNT >= AFULL_TH
//   COUNT      out  AW+1      current occupancy, 0..DEPTH
//   OVF        out  1         sticky: a push was rejected
//   UDF        out  1         sticky: a pop was rejected
// BEHAVIOUR
//   - RST=1 (async, any time, incl. mid-burst): rd/wr ptr=0, COUNT=0, IS_EMPTY=1, IS_FULL=0, IS_AEMPTY=1,
//     IS_AFULL=(AFULL_TH==0)=0, OVF=0, UDF=0, D_valid=0, registered D_out=0. Contents discarded, storage not reset.
//   - Status flags: combinational decodes of registered COUNT; they update the cycle after the accepting edge.
//   - pop_ok = POPE & ~IS_EMPTY.
//   - push_ok = PUSHE & (~IS_FULL | pop_ok): pop-and-push on a full FIFO is accepted, COUNT stays DEPTH.
//   - Push+pop on empty: pop rejected (UDF set), push accepted, COUNT becomes 1.
//   - push_ok: mem[wr_ptr] <= D_in, wr_ptr advances. pop_ok: rd_ptr advances.
//   - Both pointers wrap DEPTH-1 -> 0 (explicit compare, not modulo-2^AW).
//   - COUNT <= COUNT + push_ok - pop_ok; never exceeds DEPTH, never underflows.
//   - FWFT=1: D_out = mem[rd_ptr] combinationally; D_valid = ~IS_EMPTY.
//     Pop consumes the word currently shown.
//   - FWFT=0: on pop_ok, D_out <= mem[rd_ptr] and D_valid <= 1 for exactly one cycle.
//     Otherwise D_valid <= 0 and D_out holds its value.
//   - OVF <= 1 on PUSHE & ~push_ok; UDF <= 1 on POPE & ~pop_ok.
//   - CLR_ERR clears OVF/UDF; a set event in the same cycle wins.
//   - Rejected push or pop changes no pointer, no COUNT and no data.
// TESTING
//   1. Reset, push 0x01..0x20 (DEPTH=32) -> COUNT=32, IS_FULL=1, IS_AFULL from COUNT=30; 33rd push -> OVF=1, COUNT=32.
//   2. Drain after test 1 -> D_out sequence 0x01..0x20 in order; then POPE -> UDF=1, IS_EMPTY=1, COUNT=0.
//   3. DEPTH=5: 12 push/pop pairs -> pointers wrap twice, data order intact, COUNT stays 1.
//   4. Full FIFO, PUSHE=POPE=1 one cycle -> COUNT=32, IS_FULL=1, no OVF, head popped, new word at tail.
//   5. FWFT=0: push 0xA5, pop -> D_out=0xA5 with D_valid=1 the cycle after pop, D_valid=0 the next.
//   6. RST pulse mid-burst (COUNT=17) -> all outputs at reset values immediately; next push then pop returns the new word.

Source files
------------

// File: rtl/param_fifo.sv
// Parametrised synchronous operand FIFO with occupancy count and threshold flags.
// Supports any depth >= 2, sticky overflow/underflow and FWFT or registered read.
module param_fifo #(
    parameter int DEPTH     = 32,
    parameter int BWIDTH    = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PUSHE,
    input  logic                     POPE,
    input  logic                     CLR_ERR,
    input  logic [BWIDTH-1:0]        D_in,
    output logic [BWIDTH-1:0]        D_out,
    output logic                     D_valid,
    output logic                     IS_EMPTY,
    output logic                     IS_FULL,
    output logic                     IS_AEMPTY,
    output logic                     IS_AFULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF,
    output logic                     UDF
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C   = (AW+1)'(AFULL_TH);
    localparam logic [AW:0]   AE_C   = (AW+1)'(AEMPTY_TH);

    logic [BWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count_q;
    logic              pop_ok;
    logic              push_ok;

    assign COUNT     = count_q;
    assign IS_EMPTY  = (count_q == '0);
    assign IS_FULL   = (count_q == FULL_C);
    assign IS_AEMPTY = (count_q <= AE_C);
    assign IS_AFULL  = (count_q >= AF_C);

    // A pop frees the slot, so a push on a full FIFO is fine in the same cycle
    assign pop_ok  = POPE & ~IS_EMPTY;
    assign push_ok = PUSHE & (~IS_FULL | pop_ok);

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= D_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            OVF     <= 1'b0;
            UDF     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count_q <= count_q + {{AW{1'b0}}, push_ok}
                               - {{AW{1'b0}}, pop_ok};
            if (PUSHE & ~push_ok) begin
                OVF <= 1'b1;
            end else if (CLR_ERR) begin
                OVF <= 1'b0;
            end
            if (POPE & ~pop_ok) begin
                UDF <= 1'b1;
            end else if (CLR_ERR) begin
                UDF <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign D_out   = mem[rd_ptr];
            assign D_valid = ~IS_EMPTY;
        end else begin : g_reg
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    D_out   <= '0;
                    D_valid <= 1'b0;
                end else if (pop_ok) begin
                    D_out   <= mem[rd_ptr];
                    D_valid <= 1'b1;
                end else begin
                    D_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a 32-deep FWFT instance and a 5-deep registered-read
// instance, both checked every cycle against queue-based models.
module tb_param_fifo;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic       push [2];
    logic       pop  [2];
    logic       clr  [2];
    logic [7:0] din  [2];

    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b, em_a, em_b, fu_a, fu_b;
    logic       ae_a, ae_b, af_a, af_b;
    logic       ovf_a, ovf_b, udf_a, udf_b;
    logic [5:0] cnt_a;
    logic [3:0] cnt_b;

    int dep  [2] = '{32, 5};
    int afth [2] = '{30, 4};
    int aeth [2] = '{2, 1};
    int fw   [2] = '{1, 0};

    logic [7:0] mq [2][$];
    bit         m_ovf  [2];
    bit         m_udf  [2];
    bit         m_dv   [2];
    logic [7:0] m_dout [2];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    param_fifo #(.DEPTH(32), .BWIDTH(8)) u_a (
        .CLK(CLK), .RST(RST), .PUSHE(push[0]), .POPE(pop[0]),
        .CLR_ERR(clr[0]), .D_in(din[0]), .D_out(dout_a),
        .D_valid(dv_a), .IS_EMPTY(em_a), .IS_FULL(fu_a),
        .IS_AEMPTY(ae_a), .IS_AFULL(af_a), .COUNT(cnt_a),
        .OVF(ovf_a), .UDF(udf_a)
    );

    param_fifo #(.DEPTH(5), .BWIDTH(8), .AFULL_TH(4),
                 .AEMPTY_TH(1), .FWFT(1'b0)) u_b (
        .CLK(CLK), .RST(RST), .PUSHE(push[1]), .POPE(pop[1]),
        .CLR_ERR(clr[1]), .D_in(din[1]), .D_out(dout_b),
        .D_valid(dv_b), .IS_EMPTY(em_b), .IS_FULL(fu_b),
        .IS_AEMPTY(ae_b), .IS_AFULL(af_b), .COUNT(cnt_b),
        .OVF(ovf_b), .UDF(udf_b)
    );

    task automatic chk(input int i, input string nm, input int a, input int x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL inst%0d %s: got=%0d want=%0d t=%0t", i, nm, a, x, $time);
        end
    endtask

    task automatic chk_inst(input int i, input int c, input logic e,
                            input logic f, input logic ae, input logic af,
                            input logic ov, input logic ud, input logic dv,
                            input logic [7:0] d);
        int n;
        n = mq[i].size();
        chk(i, "count", c, n);
        chk(i, "empty", int'(e), int'(n == 0));
        chk(i, "full", int'(f), int'(n == dep[i]));
        chk(i, "aempty", int'(ae), int'(n <= aeth[i]));
        chk(i, "afull", int'(af), int'(n >= afth[i]));
        chk(i, "ovf", int'(ov), int'(m_ovf[i]));
        chk(i, "udf", int'(ud), int'(m_udf[i]));
        if (fw[i] != 0) begin
            chk(i, "dvalid", int'(dv), int'(n != 0));
            if (n != 0) chk(i, "dout", int'(d), int'(mq[i][0]));
        end else begin
            chk(i, "dvalid", int'(dv), int'(m_dv[i]));
            chk(i, "dout", int'(d), int'(m_dout[i]));
        end
    endtask

    task automatic check_all();
        chk_inst(0, cnt_a, em_a, fu_a, ae_a, af_a, ovf_a, udf_a, dv_a, dout_a);
        chk_inst(1, cnt_b, em_b, fu_b, ae_b, af_b, ovf_b, udf_b, dv_b, dout_b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_ovf[i]  = 1'b0;
            m_udf[i]  = 1'b0;
            m_dv[i]   = 1'b0;
            m_dout[i] = 8'h00;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit pop_ok, push_ok;
            int n;
            n = mq[i].size();
            pop_ok  = pop[i] && (n != 0);
            push_ok = push[i] && ((n != dep[i]) || pop_ok);
            if (pop_ok) begin
                m_dout[i] = mq[i][0];
                m_dv[i]   = 1'b1;
                void'(mq[i].pop_front());
            end else begin
                m_dv[i] = 1'b0;
            end
            if (push_ok) mq[i].push_back(din[i]);
            if (push[i] && !push_ok) m_ovf[i] = 1'b1;
            else if (clr[i]) m_ovf[i] = 1'b0;
            if (pop[i] && !pop_ok) m_udf[i] = 1'b1;
            else if (clr[i]) m_udf[i] = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_all();
    endtask

    task automatic set(input int i, input bit pu, input bit po,
                       input logic [7:0] d, input bit c = 1'b0);
        push[i] = pu;
        pop[i]  = po;
        din[i]  = d;
        clr[i]  = c;
    endtask

    task automatic idle();
        set(0, 1'b0, 1'b0, 8'h00);
        set(1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pulse_rst();
        idle();
        #2 RST = 1'b1;
        model_reset();
        #1 check_all();
        chk(0, "rst_count", cnt_a, 0);
        chk(0, "rst_empty", em_a, 1);
        chk(1, "rst_dvalid", dv_b, 0);
        chk(1, "rst_dout", dout_b, 0);
        @(negedge CLK);
        check_all();
        RST = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge CLK);
        check_all();
        chk(0, "init_aempty", ae_a, 1);
        chk(0, "init_afull", af_a, 0);
        RST = 1'b0;
        cyc();

        // fill A, one push beyond capacity
        for (int k = 1; k <= 33; k++) begin
            set(0, 1'b1, 1'b0, 8'(k));
            cyc();
            chk(0, "t1_afull", af_a, int'(k >= 30));
            chk(0, "t1_count", cnt_a, (k > 32) ? 32 : k);
        end
        chk(0, "t1_ovf", ovf_a, 1);
        chk(0, "t1_full", fu_a, 1);

        set(0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc();
        chk(0, "t4_clr", ovf_a, 0);
        set(0, 1'b1, 1'b1, 8'h77);
        cyc();
        chk(0, "t4_count", cnt_a, 32);
        chk(0, "t4_full", fu_a, 1);
        chk(0, "t4_ovf", ovf_a, 0);
        chk(0, "t4_head", dout_a, 8'h02);

        for (int k = 0; k < 32; k++) begin
            chk(0, "t2_head", dout_a, (k < 31) ? k + 2 : 8'h77);
            set(0, 1'b0, 1'b1, 8'h00);
            cyc();
        end
        cyc();
        chk(0, "t2_udf", udf_a, 1);
        chk(0, "t2_empty", em_a, 1);
        chk(0, "t2_count", cnt_a, 0);
        idle();

        // registered read on B
        set(1, 1'b1, 1'b0, 8'hA5);
        cyc();
        set(1, 1'b0, 1'b1, 8'h00);
        cyc();
        chk(1, "t5_dv", dv_b, 1);
        chk(1, "t5_dout", dout_b, 8'hA5);
        idle();
        cyc();
        chk(1, "t5_dv_drop", dv_b, 0);
        chk(1, "t5_hold", dout_b, 8'hA5);

        set(1, 1'b1, 1'b0, 8'h10);
        cyc();
        for (int k = 0; k < 12; k++) begin
            set(1, 1'b1, 1'b1, 8'(8'h20 + k));
            cyc();
            chk(1, "t3_count", cnt_b, 1);
            chk(1, "t3_dout", dout_b, (k == 0) ? 8'h10 : 8'h20 + k - 1);
        end
        set(1, 1'b0, 1'b1, 8'h00);
        cyc();
        set(1, 1'b1, 1'b1, 8'h55);
        cyc();
        chk(1, "pe_udf", udf_b, 1);
        chk(1, "pe_count", cnt_b, 1);
        chk(1, "pe_dv", dv_b, 0);
        set(1, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc();
        chk(1, "pe_clr", udf_b, 0);
        idle();

        // reset in the middle of a burst
        for (int k = 0; k < 17; k++) begin
            set(0, 1'b1, 1'b0, 8'($urandom));
            set(1, 1'b1, 1'b0, 8'($urandom));
            cyc();
        end
        chk(0, "t6_pre", cnt_a, 17);
        pulse_rst();
        set(0, 1'b1, 1'b0, 8'h3C);
        cyc();
        chk(0, "t6_head", dout_a, 8'h3C);
        set(0, 1'b0, 1'b1, 8'h00);
        cyc();
        chk(0, "t6_empty", em_a, 1);
        idle();

        // randomized phases with push/pop bias
        for (int ph = 0; ph < 3; ph++) begin
            int pp, pq;
            pp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            pq = (ph == 0) ? 30 : (ph == 1) ? 70 : 50;
            if (ph == 2) pulse_rst();
            repeat (600) begin
                for (int i = 0; i < 2; i++) begin
                    set(i, $urandom_range(99) < pp, $urandom_range(99) < pq,
                        8'($urandom), $urandom_range(99) < 5);
                end
                cyc();
            end
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
